// File: rtl/cpu_pkg.sv
// Shared types and constants for the boot-time program loader and the CPU it feeds.
package cpu_pkg;

  localparam int IW        = 9;   // instruction width
  localparam int DW        = 8;   // stream byte width
  localparam int AW        = 8;   // instruction memory address width
  localparam int CW        = 16;  // cycle counter width
  localparam int INIT_HOLD = 2;   // cycles cpu_init stays high after the last write

  typedef enum logic [2:0] {
    S_COUNT,
    S_LO,
    S_HI,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  typedef logic [IW-1:0] instr_t;
  typedef logic [DW-1:0] byte_t;

  // A HI byte carries only instr[8]; any other set bit marks a corrupt stream.
  function automatic logic hi_byte_ok(input byte_t hi);
    return (hi[DW-1:1] == '0);
  endfunction

  function automatic instr_t make_instr(input byte_t hi, input byte_t lo);
    return {hi[0], lo};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: assembles 9-bit instructions from a byte stream, writes them to
// instruction memory with the CPU held in init, then times the CPU run to halt.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int IW        = cpu_pkg::IW,
  parameter int AW        = cpu_pkg::AW,
  parameter int CW        = cpu_pkg::CW,
  parameter int INIT_HOLD = cpu_pkg::INIT_HOLD
) (
  input  logic          CLK,
  input  logic          init_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          cpu_init,
  input  logic          cpu_halt,
  output logic          done,
  output logic          load_err,
  output logic [CW-1:0] cycle_count
);

  localparam int HW = (INIT_HOLD < 2) ? 1 : $clog2(INIT_HOLD + 1);

  state_t        state_q,      state_d;
  logic          in_ready_q,   in_ready_d;
  logic          imem_we_q,    imem_we_d;
  logic [AW-1:0] imem_addr_q,  imem_addr_d;
  logic [IW-1:0] imem_wdata_q, imem_wdata_d;
  logic          cpu_init_q,   cpu_init_d;
  logic          done_q,       done_d;
  logic          load_err_q,   load_err_d;
  byte_t         n_q,          n_d;
  logic [AW-1:0] addr_ptr_q,   addr_ptr_d;
  byte_t         lo_q,         lo_d;
  logic [HW-1:0] hold_q,       hold_d;

  logic          accept;
  logic          last_pair;
  logic [AW:0]   ptr_plus_one;
  logic          cnt_en;
  logic          cnt_clr;

  assign accept       = in_valid && in_ready_q;
  assign ptr_plus_one = {1'b0, addr_ptr_q} + {{AW{1'b0}}, 1'b1};
  assign last_pair    = (ptr_plus_one == (AW+1)'(n_q));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    n_d          = n_q;
    addr_ptr_d   = addr_ptr_q;
    lo_d         = lo_q;
    hold_d       = hold_q;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;

    case (state_q)
      // A count byte seen in S_DONE starts a fresh load exactly like S_COUNT.
      S_COUNT, S_DONE: begin
        if (accept) begin
          cnt_clr = 1'b1;
          if (in_data == 8'h00) begin
            state_d = S_ERR;
          end else begin
            n_d        = in_data;
            addr_ptr_d = '0;
            state_d    = S_LO;
          end
        end
      end

      S_LO: begin
        if (accept) begin
          lo_d    = in_data;
          state_d = S_HI;
        end
      end

      S_HI: begin
        if (accept) begin
          if (!hi_byte_ok(in_data)) begin
            state_d = S_ERR;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = addr_ptr_q;
            imem_wdata_d = make_instr(in_data, lo_q);
            addr_ptr_d   = addr_ptr_q + 1'b1;
            if (last_pair) begin
              state_d = S_HOLD;
              hold_d  = '0;
            end else begin
              state_d = S_LO;
            end
          end
        end
      end

      // The first S_HOLD cycle carries the final write; INIT_HOLD more follow.
      S_HOLD: begin
        if (hold_q == HW'(INIT_HOLD)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      S_RUN: begin
        if (cpu_halt) begin
          state_d = S_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_ERR;
      end
    endcase

    // Status outputs are registered copies of what the next state implies.
    in_ready_d = (state_d == S_COUNT) || (state_d == S_LO) ||
                 (state_d == S_HI)    || (state_d == S_DONE);
    cpu_init_d = (state_d != S_RUN);
    done_d     = (state_d == S_DONE);
    load_err_d = (state_d == S_ERR);
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state_q      <= S_COUNT;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_init_q   <= 1'b1;
      done_q       <= 1'b0;
      load_err_q   <= 1'b0;
      n_q          <= '0;
      addr_ptr_q   <= '0;
      lo_q         <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_init_q   <= cpu_init_d;
      done_q       <= done_d;
      load_err_q   <= load_err_d;
      n_q          <= n_d;
      addr_ptr_q   <= addr_ptr_d;
      lo_q         <= lo_d;
      hold_q       <= hold_d;
    end
  end

  sat_counter #(
    .W (CW)
  ) u_cycle_cnt (
    .clk   (CLK),
    .rst_n (init_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .count (cycle_count)
  );

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_init   = cpu_init_q;
  assign done       = done_q;
  assign load_err   = load_err_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the single-cycle CPU's instruction fetch stage.
- Accepts a byte stream over a valid/ready handshake and assembles 9-bit instructions from it.
- Writes those instructions into instruction memory while holding the CPU in init.
- Then releases the CPU, counts executed cycles until halt, and reports done/error.

Parameters:
- IW, 9, instruction width.
- AW, 8, instruction memory address width (depth 2**AW).
- CW, 16, cycle counter width.
- INIT_HOLD, 2, CLK cycles cpu_init stays high after the last write before release (min 1).

Ports:
- CLK  in  1  clock, rising edge.
- init_n  in  1  asynchronous active-low reset.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; transfer happens when in_valid && in_ready at CLK rise.
- imem_we  out  1  instruction memory write strobe, one cycle per instruction.
- imem_addr  out  AW  write address.
- imem_wdata  out  IW  write data.
- cpu_init  out  1  drives the CPU init input, active high.
- cpu_halt  in  1  CPU halt flag.
- done  out  1  program halted normally; sticky.
- load_err  out  1  malformed stream; sticky until reset.
- cycle_count  out  CW  CPU cycles from release to halt.

Behaviour:
- Reset is asynchronous on init_n low. Register values while in reset and on exit:
  - state=S_COUNT, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_init=1, done=0, load_err=0, cycle_count=0.
  - in_ready rises on the first CLK edge after reset release.
- Stream format:
  - Byte 0 is N, the instruction count, 1..2**AW-1.
  - Then N pairs: LO byte = instr[7:0], HI byte = {7'b0, instr[8]}.
- FSM, all outputs registered:
  - S_COUNT: in_ready=1. On accept: N==0 -> S_ERR; else latch N, addr_ptr=0 -> S_LO.
  - S_LO: in_ready=1. On accept, latch the low byte -> S_HI.
  - S_HI: in_ready=1. On accept:
    - HI[7:1]!=0 -> S_ERR with no write.
    - Otherwise, in the next cycle: imem_we=1, imem_addr=addr_ptr, imem_wdata={HI[0],LO}; addr_ptr increments.
    - If this was the Nth pair -> S_HOLD, else -> S_LO.
  - S_HOLD: in_ready=0, cpu_init=1 for INIT_HOLD cycles, counted from the cycle after the last imem_we. Then cpu_init falls -> S_RUN.
  - S_RUN: in_ready=0, cpu_init=0.
    - cycle_count increments every CLK while cpu_halt=0 and saturates at all-ones.
    - cpu_halt=1 -> S_DONE; that cycle is not counted.
  - S_DONE: done=1, cpu_init=1 (CPU re-held), in_ready=1, cycle_count frozen.
    - Accepting a new count byte clears done and cycle_count and restarts as in S_COUNT.
  - S_ERR: load_err=1, cpu_init=1, in_ready=0. Exit only by reset.
- imem_we is a single-cycle pulse. It never asserts outside S_LO/S_HI/S_HOLD entry, and never while cpu_init=0.
- cpu_init is 1 in every state except S_RUN.
- in_valid with in_ready=0 has no effect. The loader never drops an accepted byte.
- cpu_halt is ignored outside S_RUN.
- Reset mid-load or mid-run aborts immediately. No partial state survives; memory contents are not cleared.
- Back-to-back bytes (in_valid held high) sustain one byte per cycle. A 2N+1 byte program loads in 2N+1 accept cycles plus 1 write cycle.

Decomposition:
- Shared package (cpu_pkg):
  - IW and data width constants.
  - State enum typedef (S_COUNT, S_LO, S_HI, S_HOLD, S_RUN, S_DONE, S_ERR).
  - Instruction word typedef.
- One sub-module: sat_counter (width parameter, enable, clear, saturating) for cycle_count.
- The FSM and the byte assembler stay in prog_loader.

Test Plan:
- Stream 03, {12,00},{34,01},{FF,00} with in_valid held -> imem writes (0,012),(1,134),(2,0FF) on consecutive pair completions; cpu_init falls INIT_HOLD cycles after the last write.
- After the above, assert cpu_halt on the 10th cycle after release -> cycle_count=9, done=1, cpu_init=1, in_ready=1.
- Count byte 00 -> load_err=1, no imem_we, in_ready=0 until init_n pulses low.
- HI byte 02 on pair 1 -> load_err=1, the write for address 0 never occurs, cpu_init stays 1.
- Random in_valid gaps during a 5-instruction load -> identical write sequence to the gapless case; no writes during gaps.
- init_n low mid-S_RUN -> cpu_init=1, cycle_count=0, state S_COUNT immediately (asynchronous, before the next CLK edge).
